// File: rtl/rename_ckpt_ctrl_pkg.sv
// Shared types and default sizing for the rename branch-checkpoint controller.
package rename_ckpt_ctrl_pkg;

  localparam int SYS_PHYS_REG_ADDR_WIDTH = 6;
  localparam int NUM_CKPT                = 4;
  localparam int DISP_W                  = 3;
  localparam int CKPT_ID_W               = $clog2(NUM_CKPT);

  typedef logic [CKPT_ID_W-1:0]                     ckpt_id_t;
  typedef logic [31:0][SYS_PHYS_REG_ADDR_WIDTH-1:0] map_tbl_t;

  typedef enum logic {
    ST_IDLE,
    ST_RECOVER
  } ckpt_state_e;

endpackage

// File: rtl/rename_ckpt_ctrl_snapshot_merge.sv
// Builds the map-table image a branch must see: current table plus renames
// from the bundle up to and including the branch slot, in slot order.
module ckpt_snapshot_merge #(
  parameter int PR_W   = 6,
  parameter int DISP_W = 3
) (
  input  logic [31:0][PR_W-1:0]       mt_cur_tbl,
  input  logic [DISP_W-1:0]           dispatch_valid,
  input  logic [DISP_W-1:0]           dispatch_is_br,
  input  logic [DISP_W-1:0]           dispatch_wr_en,
  input  logic [DISP_W-1:0][4:0]      mt_new_arch_regs,
  input  logic [DISP_W-1:0][PR_W-1:0] dispatch_pr_alloc_tags,
  output logic [31:0][PR_W-1:0]       snap_tbl
);

  logic past_br;

  // Slots after the branch belong to the predicted path and stay out.
  always_comb begin
    snap_tbl = mt_cur_tbl;
    past_br  = 1'b0;
    for (int s = 0; s < DISP_W; s++) begin
      if (!past_br && dispatch_valid[s] && dispatch_wr_en[s] &&
          mt_new_arch_regs[s] != 5'd0)
        snap_tbl[mt_new_arch_regs[s]] = dispatch_pr_alloc_tags[s];
      if (dispatch_valid[s] && dispatch_is_br[s])
        past_br = 1'b1;
    end
  end

endmodule

// File: rtl/rename_ckpt_ctrl.sv
// Branch checkpoint ring for the rename map table: allocate per branch,
// retire in order on correct resolve, squash and restore on mispredict.
module rename_ckpt_ctrl #(
  parameter int NUM_CKPT = rename_ckpt_ctrl_pkg::NUM_CKPT,
  parameter int PR_W     = rename_ckpt_ctrl_pkg::SYS_PHYS_REG_ADDR_WIDTH,
  parameter int DISP_W   = rename_ckpt_ctrl_pkg::DISP_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0][PR_W-1:0]         mt_cur_tbl,
  input  logic [DISP_W-1:0]             dispatch_valid,
  input  logic [DISP_W-1:0]             dispatch_is_br,
  input  logic [DISP_W-1:0]             dispatch_wr_en,
  input  logic [DISP_W-1:0][4:0]        mt_new_arch_regs,
  input  logic [DISP_W-1:0][PR_W-1:0]   dispatch_pr_alloc_tags,
  input  logic                          br_resolve_valid,
  input  logic [$clog2(NUM_CKPT)-1:0]   br_resolve_id,
  input  logic                          br_mispredict,
  output logic                          ckpt_alloc_valid,
  output logic [$clog2(NUM_CKPT)-1:0]   ckpt_alloc_id,
  output logic                          ckpt_stall,
  output logic [$clog2(NUM_CKPT):0]     ckpt_free_cnt,
  output logic                          fch_rec_enable,
  output logic [31:0][PR_W-1:0]         mt_checkpoint_tbl
);
  import rename_ckpt_ctrl_pkg::*;

  localparam int ID_W  = $clog2(NUM_CKPT);
  localparam int CNT_W = ID_W + 1;

  ckpt_state_e                       state_q, state_d;
  logic [ID_W-1:0]                   head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]                  count_q, count_d, free_q;
  logic [NUM_CKPT-1:0]               live_q, live_d, res_q, res_d;
  logic [NUM_CKPT-1:0][31:0][PR_W-1:0] snap_q;
  logic [31:0][PR_W-1:0]             merged_tbl;

  logic br_in_bundle, mispred_raw, mispred_ok, resolve_ok, retire;
  logic [ID_W-1:0] id_age;

  ckpt_snapshot_merge #(.PR_W(PR_W), .DISP_W(DISP_W)) u_merge (
    .mt_cur_tbl             (mt_cur_tbl),
    .dispatch_valid         (dispatch_valid),
    .dispatch_is_br         (dispatch_is_br),
    .dispatch_wr_en         (dispatch_wr_en),
    .mt_new_arch_regs       (mt_new_arch_regs),
    .dispatch_pr_alloc_tags (dispatch_pr_alloc_tags),
    .snap_tbl               (merged_tbl)
  );

  assign br_in_bundle = |(dispatch_valid & dispatch_is_br);
  assign mispred_raw  = br_resolve_valid & br_mispredict;
  assign mispred_ok   = mispred_raw & live_q[br_resolve_id];
  assign resolve_ok   = br_resolve_valid & ~br_mispredict & live_q[br_resolve_id];
  // Age relative to head orders entries in program order across the wrap.
  assign id_age       = br_resolve_id - head_q;

  // Head squashed by its own mispredict must not also retire.
  assign retire = live_q[head_q] & res_q[head_q] &
                  ~(mispred_ok & (head_q == br_resolve_id));

  assign ckpt_stall       = (count_q == CNT_W'(NUM_CKPT)) | (state_q == ST_RECOVER) |
                            mispred_raw;
  assign ckpt_alloc_valid = br_in_bundle & ~ckpt_stall & ~mispred_raw;
  assign ckpt_alloc_id    = tail_q;
  assign ckpt_free_cnt    = free_q;

  always_comb begin
    live_d  = live_q;
    res_d   = res_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + CNT_W'(ckpt_alloc_valid) - CNT_W'(retire);
    if (resolve_ok)
      res_d[br_resolve_id] = 1'b1;
    if (retire) begin
      live_d[head_q] = 1'b0;
      res_d[head_q]  = 1'b0;
      head_d         = head_q + 1'b1;
    end
    if (mispred_ok) begin
      for (int i = 0; i < NUM_CKPT; i++) begin
        if (ID_W'(ID_W'(i) - head_q) >= id_age) begin
          live_d[i] = 1'b0;
          res_d[i]  = 1'b0;
        end
      end
      tail_d  = br_resolve_id;
      count_d = CNT_W'(id_age) - CNT_W'(retire);
    end else if (ckpt_alloc_valid) begin
      live_d[tail_q] = 1'b1;
      res_d[tail_q]  = 1'b0;
      tail_d         = tail_q + 1'b1;
    end
  end

  // Each accepted mispredict buys exactly one restore cycle.
  always_comb begin
    state_d        = ST_IDLE;
    fch_rec_enable = (state_q == ST_RECOVER);
    if (mispred_ok)
      state_d = ST_RECOVER;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= ST_IDLE;
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      free_q            <= CNT_W'(NUM_CKPT);
      live_q            <= '0;
      res_q             <= '0;
      mt_checkpoint_tbl <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      free_q  <= CNT_W'(NUM_CKPT) - count_d;
      live_q  <= live_d;
      res_q   <= res_d;
      if (mispred_ok)
        mt_checkpoint_tbl <= snap_q[br_resolve_id];
    end
  end

  // Snapshot payload is qualified by live bits, so it needs no reset.
  always_ff @(posedge clk) begin
    if (ckpt_alloc_valid)
      snap_q[tail_q] <= merged_tbl;
  end

endmodule
